// File: rtl/lc3b_muldiv_unit_pkg.sv
// Shared types for the LC-3b iterative multiply/divide unit.
package lc3b_muldiv_unit_pkg;

  localparam int LC3B_WORD_WIDTH = 16;

  typedef logic [LC3B_WORD_WIDTH-1:0]   lc3b_word;
  typedef logic [2*LC3B_WORD_WIDTH-1:0] lc3b_dword;

  typedef enum logic [1:0] {
    md_idle,
    md_mul,
    md_div,
    md_done
  } lc3b_muldiv_state;

endpackage

// File: rtl/lc3b_muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and the mul/div unit (slave).
interface lc3b_muldiv_unit_if #(
  parameter int WIDTH = lc3b_muldiv_unit_pkg::LC3B_WORD_WIDTH
) ();

  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_zero;

  modport master (
    output start, op_div, a, b, kill,
    input  busy, done, result_lo, result_hi, div_zero
  );

  modport slave (
    input  start, op_div, a, b, kill,
    output busy, done, result_lo, result_hi, div_zero
  );

endinterface

// File: rtl/lc3b_muldiv_unit_datapath.sv
// Operand, accumulator and result registers plus the shift-add / restoring-divide step logic.
// Working registers are separate from the result registers so results stay stable mid-op.
module lc3b_muldiv_unit_datapath
  import lc3b_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = LC3B_WORD_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    count,
  input  logic             mul_step,
  input  logic             div_step,
  input  logic             commit,
  input  logic             commit_dz,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;

  // One radix-2 step of each algorithm; the 17-bit compare keeps the shifted remainder exact.
  always_comb begin
    addend    = '0;
    acc_next  = acc;
    rem_shift = '0;
    rem_ge    = 1'b0;
    rem_next  = rem;
    quot_next = quot;

    addend    = {{WIDTH{1'b0}}, op_a} << count;
    acc_next  = op_b[0] ? (acc + addend) : acc;

    rem_shift = {rem, op_a[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, op_b});
    rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - op_b) : rem_shift[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], rem_ge};
  end

  // Working registers: latch operands on start, then advance one bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
      rem  <= '0;
      quot <= '0;
    end else if (load) begin
      op_a <= a;
      op_b <= b;
      acc  <= '0;
      rem  <= '0;
      quot <= '0;
    end else if (mul_step) begin
      acc  <= acc_next;
      op_b <= op_b >> 1;
    end else if (div_step) begin
      rem  <= rem_next;
      quot <= quot_next;
      op_a <= op_a << 1;
    end
  end

  // Result registers: updated only when an operation completes, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
    end else begin
      if (load) begin
        div_zero <= 1'b0;
      end
      if (commit_dz) begin
        result_lo <= '1;
        result_hi <= a;
        div_zero  <= 1'b1;
      end else if (commit) begin
        if (div_step) begin
          result_lo <= quot_next;
          result_hi <= rem_next;
        end else begin
          result_lo <= acc_next[WIDTH-1:0];
          result_hi <= acc_next[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/lc3b_muldiv_unit.sv
// EX-stage iterative unsigned multiply/divide unit: FSM, iteration counter and handshake.
// The arithmetic lives in lc3b_muldiv_unit_datapath.
module lc3b_muldiv_unit
  import lc3b_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = LC3B_WORD_WIDTH
) (
  input logic               clk,
  input logic               reset,
  lc3b_muldiv_unit_if.slave bus
);

  localparam int           CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  lc3b_muldiv_state state_q;
  lc3b_muldiv_state state_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic load;
  logic mul_step;
  logic div_step;
  logic commit;
  logic commit_dz;

  // State and iteration counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= md_idle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath control; kill beats start, and a zero divisor finishes at once.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load      = 1'b0;
    mul_step  = 1'b0;
    div_step  = 1'b0;
    commit    = 1'b0;
    commit_dz = 1'b0;

    case (state_q)
      md_idle, md_done: begin
        state_d = md_idle;
        if (bus.start && !bus.kill) begin
          load    = 1'b1;
          count_d = '0;
          if (bus.op_div && (bus.b == '0)) begin
            state_d   = md_done;
            commit_dz = 1'b1;
          end else begin
            state_d = bus.op_div ? md_div : md_mul;
          end
        end
      end
      md_mul: begin
        if (bus.kill) begin
          state_d = md_idle;
        end else begin
          mul_step = 1'b1;
          count_d  = count_q + CW'(1);
          if (count_q == LAST) begin
            state_d = md_done;
            commit  = 1'b1;
          end
        end
      end
      md_div: begin
        if (bus.kill) begin
          state_d = md_idle;
        end else begin
          div_step = 1'b1;
          count_d  = count_q + CW'(1);
          if (count_q == LAST) begin
            state_d = md_done;
            commit  = 1'b1;
          end
        end
      end
      default: begin
        state_d = md_idle;
      end
    endcase
  end

  assign bus.busy = (state_q == md_mul) || (state_q == md_div);
  assign bus.done = (state_q == md_done);

  lc3b_muldiv_unit_datapath #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .a         (bus.a),
    .b         (bus.b),
    .count     (count_q),
    .mul_step  (mul_step),
    .div_step  (div_step),
    .commit    (commit),
    .commit_dz (commit_dz),
    .result_lo (bus.result_lo),
    .result_hi (bus.result_hi),
    .div_zero  (bus.div_zero)
  );

endmodule

// File: tb/tb_lc3b_muldiv_unit.sv
// Self-checking bench for lc3b_muldiv_unit: directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_lc3b_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  lc3b_muldiv_unit_if #(.WIDTH(16)) dut_if ();

  lc3b_muldiv_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  always #5 clk = ~clk;

  // Directed table: {div_zero, hi, lo}, latency to done, busy cycles.
  bit          d_div  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] d_a    [4] = '{16'h0007, 16'hFFFF, 16'h0064, 16'h1234};
  logic [15:0] d_b    [4] = '{16'h0006, 16'hFFFF, 16'h0007, 16'h0000};
  logic [32:0] d_exp  [4] = '{33'h0_0000_002A, 33'h0_FFFE_0001, 33'h0_0002_000E, 33'h1_1234_FFFF};
  int          d_lat  [4] = '{17, 17, 17, 1};
  int          d_busy [4] = '{16, 16, 16, 0};

  // Reference model: {div_zero, hi, lo} from unsigned arithmetic.
  function automatic logic [32:0] model(input bit is_div, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    if (!is_div) begin
      p = 32'(x) * 32'(y);
      return {1'b0, p};
    end else if (y == 16'h0000) begin
      return {1'b1, x, 16'hFFFF};
    end else begin
      return {1'b0, x % y, x / y};
    end
  endfunction

  function automatic logic [32:0] result_now();
    return {dut_if.div_zero, dut_if.result_hi, dut_if.result_lo};
  endfunction

  function automatic logic [34:0] status_now();
    return {dut_if.busy, dut_if.done, dut_if.div_zero, dut_if.result_hi, dut_if.result_lo};
  endfunction

  // Caller has raised start in cycle 0; advance until done (bounded), counting busy cycles
  // and any result change seen before done.
  task automatic wait_done(output int lat, output int busy_cyc, output int changes);
    logic [15:0] lo0;
    logic [15:0] hi0;
    lo0      = dut_if.result_lo;
    hi0      = dut_if.result_hi;
    lat      = 0;
    busy_cyc = 0;
    changes  = 0;
    do begin
      @(posedge clk);
      #1;
      dut_if.start = 1'b0;
      dut_if.a     = 16'($urandom);
      dut_if.b     = 16'($urandom);
      lat++;
      if (dut_if.busy === 1'b1) busy_cyc++;
      if (dut_if.done !== 1'b1 && (dut_if.result_lo !== lo0 || dut_if.result_hi !== hi0)) changes++;
    end while (dut_if.done !== 1'b1 && lat < 40);
    if (dut_if.done !== 1'b1) lat = -1;
  endtask

  task automatic run_op(input bit is_div, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output int busy_cyc, output int changes);
    @(posedge clk);
    #1;
    dut_if.start  = 1'b1;
    dut_if.op_div = is_div;
    dut_if.a      = x;
    dut_if.b      = y;
    wait_done(lat, busy_cyc, changes);
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    dut_if.start  = 1'b1;
    dut_if.op_div = 1'b0;
    dut_if.a      = 16'h0005;
    dut_if.b      = 16'h0005;
    dut_if.kill   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    vectors++;
    if (status_now() !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h expected %h", status_now(), 35'h0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (status_now() !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %h expected %h", status_now(), 35'h0);
    end
  endtask

  task automatic test_directed();
    int lat;
    int busy_cyc;
    int changes;
    for (int i = 0; i < 4; i++) begin
      run_op(d_div[i], d_a[i], d_b[i], lat, busy_cyc, changes);
      vectors++;
      if (lat !== d_lat[i]) begin
        miscompares++;
        $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, d_lat[i]);
      end
      vectors++;
      if (busy_cyc !== d_busy[i]) begin
        miscompares++;
        $display("[TB] FAIL directed%0d_busy_cycles: got %0d expected %0d", i, busy_cyc, d_busy[i]);
      end
      vectors++;
      if (changes !== 0) begin
        miscompares++;
        $display("[TB] FAIL directed%0d_mid_op_change: got %0d expected 0", i, changes);
      end
      vectors++;
      if (result_now() !== d_exp[i]) begin
        miscompares++;
        $display("[TB] FAIL directed%0d_result: got %h expected %h", i, result_now(), d_exp[i]);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (status_now() !== {2'b00, d_exp[i]}) begin
        miscompares++;
        $display("[TB] FAIL directed%0d_hold_after_done: got %h expected %h", i, status_now(), {2'b00, d_exp[i]});
      end
    end
  endtask

  task automatic test_kill();
    int          lat;
    int          busy_cyc;
    int          changes;
    int          dones;
    logic [34:0] held;
    held = {3'b000, 16'h1234, 16'hFFFF};
    @(posedge clk);
    #1;
    dut_if.start  = 1'b1;
    dut_if.op_div = 1'b0;
    dut_if.a      = 16'($urandom);
    dut_if.b      = 16'($urandom);
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (dut_if.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL kill_busy_before: got %b expected 1", dut_if.busy);
    end
    dut_if.kill = 1'b1;
    @(posedge clk);
    #1;
    dut_if.kill = 1'b0;
    vectors++;
    if (status_now() !== held) begin
      miscompares++;
      $display("[TB] FAIL kill_aborted_state: got %h expected %h", status_now(), held);
    end
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (dut_if.done === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("[TB] FAIL kill_no_done: got %0d done pulses expected 0", dones);
    end
    dut_if.start  = 1'b1;
    dut_if.kill   = 1'b1;
    dut_if.op_div = 1'b0;
    dut_if.a      = 16'h0003;
    dut_if.b      = 16'h0003;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    dut_if.kill  = 1'b0;
    vectors++;
    if (status_now() !== held) begin
      miscompares++;
      $display("[TB] FAIL kill_with_start_ignored: got %h expected %h", status_now(), held);
    end
    run_op(1'b1, 16'd9, 16'd2, lat, busy_cyc, changes);
    vectors++;
    if (lat !== 17) begin
      miscompares++;
      $display("[TB] FAIL kill_followup_latency: got %0d expected 17", lat);
    end
    vectors++;
    if (result_now() !== model(1'b1, 16'd9, 16'd2)) begin
      miscompares++;
      $display("[TB] FAIL kill_followup_result: got %h expected %h", result_now(), model(1'b1, 16'd9, 16'd2));
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int busy_cyc;
    int changes;
    run_op(1'b0, 16'h0123, 16'h0045, lat, busy_cyc, changes);
    vectors++;
    if (result_now() !== model(1'b0, 16'h0123, 16'h0045)) begin
      miscompares++;
      $display("[TB] FAIL midreset_setup_result: got %h expected %h", result_now(), model(1'b0, 16'h0123, 16'h0045));
    end
    @(posedge clk);
    #1;
    dut_if.start  = 1'b1;
    dut_if.op_div = 1'b1;
    dut_if.a      = 16'h1234;
    dut_if.b      = 16'h0007;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (status_now() !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %h expected %h", status_now(), 35'h0);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (status_now() !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_stays_idle: got %h expected %h", status_now(), 35'h0);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    int          busy_cyc;
    int          changes;
    logic [15:0] z_a [2];
    z_a[0] = 16'hBEEF;
    z_a[1] = 16'h0042;
    run_op(1'b0, 16'd3, 16'd5, lat, busy_cyc, changes);
    vectors++;
    if (result_now() !== model(1'b0, 16'd3, 16'd5)) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_result: got %h expected %h", result_now(), model(1'b0, 16'd3, 16'd5));
    end
    dut_if.start  = 1'b1;
    dut_if.op_div = 1'b0;
    dut_if.a      = 16'd2;
    dut_if.b      = 16'd2;
    wait_done(lat, busy_cyc, changes);
    vectors++;
    if (lat !== 17 || changes !== 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_timing: got lat %0d changes %0d expected 17 and 0", lat, changes);
    end
    vectors++;
    if (result_now() !== model(1'b0, 16'd2, 16'd2)) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_result: got %h expected %h", result_now(), model(1'b0, 16'd2, 16'd2));
    end
    for (int i = 0; i < 2; i++) begin
      dut_if.start  = 1'b1;
      dut_if.op_div = 1'b1;
      dut_if.a      = z_a[i];
      dut_if.b      = 16'h0000;
      wait_done(lat, busy_cyc, changes);
      vectors++;
      if (lat !== 1) begin
        miscompares++;
        $display("[TB] FAIL b2b_divzero%0d_latency: got %0d expected 1", i, lat);
      end
      vectors++;
      if (result_now() !== model(1'b1, z_a[i], 16'h0000)) begin
        miscompares++;
        $display("[TB] FAIL b2b_divzero%0d_result: got %h expected %h", i, result_now(), model(1'b1, z_a[i], 16'h0000));
      end
    end
  endtask

  task automatic test_random();
    int          lat;
    int          busy_cyc;
    int          changes;
    int          exp_lat;
    bit          is_div;
    logic [15:0] x;
    logic [15:0] y;
    logic [32:0] exp;
    for (int n = 0; n < 40; n++) begin
      is_div = 1'($urandom_range(0, 1));
      x      = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       y = 16'h0000;
        1:       y = 16'($urandom_range(1, 3));
        2:       y = x;
        default: y = 16'($urandom);
      endcase
      exp     = model(is_div, x, y);
      exp_lat = (is_div && y == 16'h0000) ? 1 : 17;
      run_op(is_div, x, y, lat, busy_cyc, changes);
      vectors++;
      if (lat !== exp_lat) begin
        miscompares++;
        $display("[TB] FAIL random%0d_latency: got %0d expected %0d", n, lat, exp_lat);
      end
      vectors++;
      if (result_now() !== exp) begin
        miscompares++;
        $display("[TB] FAIL random%0d_result div=%0d a=%h b=%h: got %h expected %h", n, is_div, x, y, result_now(), exp);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    dut_if.start  = 1'b0;
    dut_if.op_div = 1'b0;
    dut_if.a      = 16'h0000;
    dut_if.b      = 16'h0000;
    dut_if.kill   = 1'b0;
    test_reset();
    test_directed();
    test_kill();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
